// File: rtl/uart_frame_core.sv
// uart_frame_core: parametrised full-duplex UART.
//
// The TX side accepts words over a valid/ready handshake into a small FIFO
// and serialises them LSB first as start, data, optional parity and stop
// bits. The RX side synchronises the line, qualifies the start bit at
// mid-bit, samples every following bit one bit time later, and reports the
// word with parity and framing error flags.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   uart_rx         serial input (asynchronous, idle high)
//   uart_tx         serial output (registered, idle high)
//   tx_data         word to send
//   tx_valid        tx_data valid
//   tx_ready        FIFO not full; transfer on tx_valid & tx_ready
//   tx_busy         FIFO non-empty or frame in progress
//   rx_data         last received word, held until the next frame completes
//   rx_valid        one-cycle pulse when rx_data and error flags update
//   rx_parity_err   parity mismatch for the flagged frame
//   rx_frame_err    first stop bit sampled low for the flagged frame
module uart_frame_core #(
  parameter int CLKS_PER_BIT  = 234,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(TX_FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int IDX_W  = 4;

  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(TX_FIFO_DEPTH);
  localparam bit                HAS_PARITY = (PARITY != 0);

  // Parity bit that completes the word: odd -> total ones odd, even -> even.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem_q [TX_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]    count_q, count_d;
  logic                 tx_ready_q;
  logic                 push, pop, fifo_empty;

  assign push       = tx_valid & tx_ready_q;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      // Registered from the next count so a full FIFO never sees a write.
      tx_ready_q <= (count_d < FIFO_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_busy_q;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt_q == BIT_LAST);

  // The line bit is a function of the current state and is registered, so
  // uart_tx trails the state by one clock: a pop in IDLE shows the start
  // edge two clocks after the handshake that filled the FIFO.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    uart_tx_d  = 1'b1;
    pop        = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem_q[rd_ptr_q];
          tx_par_d   = parity_bit(fifo_mem_q[rd_ptr_q]);
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        uart_tx_d = 1'b0;
        if (tx_tick) begin
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        uart_tx_d = tx_shift_q[0];
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_idx_q == DATA_LAST) begin
            tx_idx_d   = '0;
            tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        uart_tx_d = tx_par_q;
        if (tx_tick) begin
          tx_idx_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        uart_tx_d = 1'b1;
        if (tx_tick) begin
          if (tx_idx_q == STOP_LAST) begin
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop        = 1'b1;
              tx_shift_d = fifo_mem_q[rd_ptr_q];
              tx_par_d   = parity_bit(fifo_mem_q[rd_ptr_q]);
              tx_state_d = TX_START;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      uart_tx_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      uart_tx_q  <= uart_tx_d;
      // Same one-clock lag as uart_tx, so busy falls as the last stop bit ends.
      tx_busy_q  <= !fifo_empty || (tx_state_q != TX_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    tx_par_q   <= tx_par_d;
  end

  // ---------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t            rx_state_q, rx_state_d;
  logic                 rx_sync1_q, rx_sync2_q;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-bit re-check rejects glitches shorter than half a bit.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == DATA_LAST) begin
            rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync2_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_perr_d  = HAS_PARITY && (parity_bit(rx_shift_q) != rx_par_q);
          rx_ferr_d  = !rx_sync2_q;
          // A low stop bit (break) must see the line high again before
          // another start can be recognised, giving one report per break.
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    rx_par_q   <= rx_par_d;
  end

  assign uart_tx       = uart_tx_q;
  assign tx_ready      = tx_ready_q;
  assign tx_busy       = tx_busy_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_frame_core.sv
`timescale 1ns/1ps
// Bench for uart_frame_core: an 8N1 instance (TX and RX scenarios) and a
// 7-bit even-parity instance (RX parity scenarios), both at 16 clocks/bit.
module tb_uart_frame_core;

  localparam int CPB    = 16;
  localparam int FRAME8 = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8N1 instance
  logic       rx8  = 1'b1;
  logic       tx8;
  logic [7:0] txd8 = 8'h00;
  logic       txv8 = 1'b0;
  logic       txr8, txb8;
  logic [7:0] rxd8;
  logic       rxv8, rxpe8, rxfe8;

  // 7E1 instance
  logic       rx7  = 1'b1;
  logic       tx7;
  logic [6:0] txd7 = 7'h00;
  logic       txv7 = 1'b0;
  logic       txr7, txb7;
  logic [6:0] rxd7;
  logic       rxv7, rxpe7, rxfe7;

  uart_frame_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .TX_FIFO_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .uart_rx(rx8), .uart_tx(tx8),
    .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8), .tx_busy(txb8),
    .rx_data(rxd8), .rx_valid(rxv8), .rx_parity_err(rxpe8), .rx_frame_err(rxfe8)
  );

  uart_frame_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(1), .TX_FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst), .uart_rx(rx7), .uart_tx(tx7),
    .tx_data(txd7), .tx_valid(txv7), .tx_ready(txr7), .tx_busy(txb7),
    .rx_data(rxd7), .rx_valid(rxv7), .rx_parity_err(rxpe7), .rx_frame_err(rxfe7)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic abort_rx = 1'b0;

  // Scoreboard queues. TX entries are {start, stop, byte}; RX entries are
  // {parity_err, frame_err, data}.
  logic [9:0] tx_exp[$];
  logic [9:0] tx_obs[$];
  int         tx_start_q[$];
  logic [9:0] rx8_exp[$];
  logic [9:0] rx8_obs[$];
  logic [9:0] rx7_exp[$];
  logic [9:0] rx7_obs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder for uart_tx of the 8N1 instance, sampling mid-bit.
  initial begin : tx_mon
    logic       act;
    int         cnt, k, start_cyc;
    logic [7:0] byte_v;
    logic       start_v;
    act = 1'b0; cnt = 0; start_cyc = 0; byte_v = 8'h00; start_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx8 === 1'b0) begin
          act = 1'b1; cnt = 0; start_cyc = cyc;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          k = cnt / CPB;
          if (k == 0) start_v = tx8;
          else if (k <= 8) byte_v[k-1] = tx8;
          else begin
            tx_obs.push_back({start_v, tx8, byte_v});
            tx_start_q.push_back(start_cyc);
            act = 1'b0;
          end
        end
      end
    end
  end

  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rxv8 === 1'b1) rx8_obs.push_back({rxpe8, rxfe8, rxd8});
      if (rxv7 === 1'b1) rx7_obs.push_back({rxpe7, rxfe7, 1'b0, rxd7});
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic send8(input logic [7:0] d, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx8 = bits[i];
      repeat (CPB) @(negedge clk);
      if (abort_rx) begin rx8 = 1'b1; return; end
    end
    rx8 = 1'b1;
  endtask

  task automatic send7(input logic [6:0] d, input logic parb, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, parb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx7 = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx7 = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx8 !== 1'b1)   begin errors++; $display("FAIL reset_uart_tx: got %b expected 1", tx8); end
    checks++; if (txr8 !== 1'b1)  begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", txr8); end
    checks++; if (txb8 !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", txb8); end
    checks++; if (rxd8 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rxd8); end
    checks++; if (rxv8 !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rxv8); end
    checks++; if ({rxpe8, rxfe8} !== 2'b00) begin errors++; $display("FAIL reset_err_flags: got %b expected 00", {rxpe8, rxfe8}); end
    checks++; if (tx7 !== 1'b1)   begin errors++; $display("FAIL reset_uart_tx7: got %b expected 1", tx7); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx_single();
    logic [9:0] e, o;
    txd8 = 8'h55; txv8 = 1'b1;
    @(negedge clk);   // handshake on the posedge just passed
    txv8 = 1'b0;
    tx_exp.push_back({2'b01, 8'h55});
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL tx_latency_edge0: got %b expected 1", tx8); end
    @(negedge clk);
    checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL tx_latency_edge1: got %b expected 1", tx8); end
    @(negedge clk);
    checks++; if (tx8 !== 1'b0) begin errors++; $display("FAIL tx_latency_edge2: got %b expected 0", tx8); end
    repeat (155) @(negedge clk);
    checks++; if (txb8 !== 1'b1) begin errors++; $display("FAIL tx_busy_during_stop: got %b expected 1", txb8); end
    repeat (10) @(negedge clk);
    checks++; if (txb8 !== 1'b0) begin errors++; $display("FAIL tx_busy_after_stop: got %b expected 0", txb8); end
    checks++;
    if (tx_obs.size() != 1) begin
      errors++; $display("FAIL tx_single_count: got %0d frames expected 1", tx_obs.size());
    end else begin
      e = tx_exp.pop_front(); o = tx_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL tx_single_frame: got %h expected %h", o, e); end
    end
    tx_exp.delete(); tx_obs.delete(); tx_start_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [5];
    logic [9:0] e, o;
    int guard, stalls;
    b[0] = 8'hA1; b[1] = 8'h3C; b[2] = 8'h0F; b[3] = 8'hF0; b[4] = 8'h96;
    stalls = 0;
    txv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      txd8 = b[i]; guard = 0;
      while (txr8 !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
      stalls += guard;
      tx_exp.push_back({2'b01, b[i]});
      @(negedge clk);
    end
    txv8 = 1'b0;
    checks++; if (stalls != 0) begin errors++; $display("FAIL b2b_accept_stalls: got %0d stall cycles expected 0", stalls); end
    checks++; if (txr8 !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", txr8); end
    repeat (100) @(negedge clk);
    checks++; if (txr8 !== 1'b0) begin errors++; $display("FAIL b2b_full_hold: got %b expected 0", txr8); end
    guard = 0;
    while (txb8 === 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
    checks++; if (guard >= 2000) begin errors++; $display("FAIL b2b_busy_timeout: busy still %b after %0d cycles", txb8, guard); end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_obs.size() != 5 || tx_start_q.size() != 5) begin
      errors++; $display("FAIL b2b_count: got %0d frames expected 5", tx_obs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        e = tx_exp.pop_front(); o = tx_obs.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", i, o, e); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (tx_start_q[i] - tx_start_q[i-1] != FRAME8) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected %0d", i, tx_start_q[i] - tx_start_q[i-1], FRAME8);
        end
      end
    end
    tx_exp.delete(); tx_obs.delete(); tx_start_q.delete();
  endtask

  task automatic test_rx_parity();
    logic [9:0] e, o;
    rx7_exp.push_back({2'b00, 1'b0, 7'h41});
    send7(7'h41, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    rx7_exp.push_back({2'b10, 1'b0, 7'h41});
    send7(7'h41, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (rx7_obs.size() != 2) begin
      errors++; $display("FAIL parity_valid_count: got %0d pulses expected 2", rx7_obs.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = rx7_exp.pop_front(); o = rx7_obs.pop_front();
        checks++; if (o !== e) begin errors++; $display("FAIL parity_frame%0d: got %h expected %h", i, o, e); end
      end
    end
    checks++; if (rxpe7 !== 1'b1 || rxd7 !== 7'h41) begin errors++; $display("FAIL parity_hold: got err=%b data=%h expected err=1 data=41", rxpe7, rxd7); end
    rx7_exp.delete(); rx7_obs.delete();
  endtask

  task automatic test_glitch();
    logic [9:0] e, o;
    rx8 = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx8 = 1'b1;
    repeat (CPB) @(negedge clk);
    checks++; if (rx8_obs.size() != 0) begin errors++; $display("FAIL glitch_no_valid: got %0d pulses expected 0", rx8_obs.size()); end
    rx8_exp.push_back({2'b00, 8'hA5});
    send8(8'hA5, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++;
    if (rx8_obs.size() != 1) begin
      errors++; $display("FAIL glitch_then_frame_count: got %0d pulses expected 1", rx8_obs.size());
    end else begin
      e = rx8_exp.pop_front(); o = rx8_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL glitch_then_frame: got %h expected %h", o, e); end
    end
    rx8_exp.delete(); rx8_obs.delete();
  endtask

  task automatic test_break();
    logic [9:0] e, o;
    rx8_exp.push_back({2'b01, 8'h00});
    rx8 = 1'b0;
    repeat (3 * FRAME8) @(negedge clk);
    rx8 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (rx8_obs.size() != 1) begin
      errors++; $display("FAIL break_valid_count: got %0d pulses expected 1", rx8_obs.size());
    end else begin
      e = rx8_exp.pop_front(); o = rx8_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL break_frame: got %h expected %h", o, e); end
    end
    rx8_exp.delete(); rx8_obs.delete();
    rx8_exp.push_back({2'b00, 8'h3C});
    send8(8'h3C, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++;
    if (rx8_obs.size() != 1) begin
      errors++; $display("FAIL after_break_count: got %0d pulses expected 1", rx8_obs.size());
    end else begin
      e = rx8_exp.pop_front(); o = rx8_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL after_break_frame: got %h expected %h", o, e); end
    end
    rx8_exp.delete(); rx8_obs.delete();
  endtask

  task automatic test_reset_mid();
    logic [9:0] e, o;
    txd8 = 8'h00; txv8 = 1'b1;
    repeat (2) @(negedge clk);
    txv8 = 1'b0;
    fork
      send8(8'hE7, 1'b1);
      begin
        repeat (60) @(negedge clk);
        checks++; if (tx8 !== 1'b0) begin errors++; $display("FAIL pre_reset_tx_low: got %b expected 0", tx8); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx8 !== 1'b1) begin errors++; $display("FAIL async_reset_tx_high: got %b expected 1", tx8); end
        abort_rx = 1'b1; rx8 = 1'b1;
        @(negedge clk);
        checks++; if (txr8 !== 1'b1 || txb8 !== 1'b0) begin errors++; $display("FAIL reset_mid_fifo: got ready=%b busy=%b expected ready=1 busy=0", txr8, txb8); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    abort_rx = 1'b0;
    repeat (2 * FRAME8) @(negedge clk);
    checks++; if (tx_obs.size() != 0 || txb8 !== 1'b0) begin errors++; $display("FAIL reset_mid_no_tx: got %0d frames busy=%b expected 0 frames busy=0", tx_obs.size(), txb8); end
    checks++; if (rx8_obs.size() != 0) begin errors++; $display("FAIL reset_mid_no_rx_valid: got %0d pulses expected 0", rx8_obs.size()); end
    rx8_exp.push_back({2'b00, 8'h81});
    send8(8'h81, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++;
    if (rx8_obs.size() != 1) begin
      errors++; $display("FAIL reset_mid_clean_count: got %0d pulses expected 1", rx8_obs.size());
    end else begin
      e = rx8_exp.pop_front(); o = rx8_obs.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL reset_mid_clean_frame: got %h expected %h", o, e); end
    end
    rx8_exp.delete(); rx8_obs.delete();
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_parity();
    test_glitch();
    test_break();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
